// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared types and constants for the data-bus arbiter.
// State/slave-select encodings, parameter defaults, latched request bundle.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        SEL_DM = 1'b0,
        SEL_IO = 1'b1
    } sel_t;

    localparam logic [15:0] IO_BASE_DEF  = 16'hFFFF;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;
    localparam int          TIMEOUT_DEF  = 15;
    localparam int          CNT_W        = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
        logic        grant;
        sel_t        sel;
    } req_t;

    function automatic sel_t decode_sel(
        input logic [31:0] addr,
        input logic [15:0] io_base
    );
        return (addr[31:16] == io_base) ? SEL_IO : SEL_DM;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr.sv
// rr_arbiter2: two-requester round-robin grant with a last_grant register.
// Ports: clk, rst_n, req[1:0], update/upd_grant in; gnt_valid, gnt_idx, last_grant out.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       upd_grant,
    output logic       gnt_valid,
    output logic       gnt_idx,
    output logic       last_grant
);

    // Reset to 1 so master 0 wins the first contested arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (update) begin
            last_grant <= upd_grant;
        end
    end

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        unique case (1'b1)
            (req == 2'b11): gnt_idx = ~last_grant;
            (req == 2'b10): gnt_idx = 1'b1;
            default:        gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master/two-slave data-bus arbiter with timeout watchdog.
// Ports: g_clk, g_rst_n; m0_*/m1_* master side; dm_*/io_* slave side.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter logic [15:0] IO_BASE  = IO_BASE_DEF,
    parameter int          TIMEOUT  = TIMEOUT_DEF,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic        g_clk,
    input  logic        g_rst_n,

    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    output logic        m0_err,

    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        m1_err,

    output logic        dm_read,
    output logic        dm_write,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ready,

    output logic        io_read,
    output logic        io_write,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    input  logic [31:0] io_rdata,
    input  logic        io_ready
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    state_t            state;
    req_t              req_q;
    logic [CNT_W-1:0]  cnt;
    logic              err_q;
    logic [31:0]       rdata_q;

    logic        gnt_valid;
    logic        gnt_idx;
    logic        last_grant;
    logic [31:0] gnt_addr;
    logic [31:0] gnt_wdata;
    logic        gnt_write;

    logic        busy;
    logic        resp;
    logic        dm_sel;
    logic        io_sel;
    logic        slv_ready;
    logic [31:0] slv_rdata;

    rr_arbiter2 u_rr (
        .clk        (g_clk),
        .rst_n      (g_rst_n),
        .req        ({m1_read | m1_write,
                      m0_read | m0_write}),
        .update     (resp),
        .upd_grant  (req_q.grant),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .last_grant (last_grant)
    );

    assign gnt_addr  = gnt_idx ? m1_addr  : m0_addr;
    assign gnt_wdata = gnt_idx ? m1_wdata : m0_wdata;
    // Write wins when a master raises both strobes.
    assign gnt_write = gnt_idx ? m1_write : m0_write;

    assign busy   = (state == BUSY);
    assign resp   = (state == RESP);
    assign dm_sel = busy && (req_q.sel == SEL_DM);
    assign io_sel = busy && (req_q.sel == SEL_IO);

    assign slv_ready = (req_q.sel == SEL_IO) ? io_ready : dm_ready;
    assign slv_rdata = (req_q.sel == SEL_IO) ? io_rdata : dm_rdata;

    always_ff @(posedge g_clk or negedge g_rst_n) begin
        if (!g_rst_n) begin
            state   <= IDLE;
            req_q   <= '0;
            cnt     <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        req_q.grant <= gnt_idx;
                        req_q.addr  <= gnt_addr;
                        req_q.wdata <= gnt_wdata;
                        req_q.write <= gnt_write;
                        req_q.sel   <= decode_sel(gnt_addr, IO_BASE);
                        cnt         <= '0;
                        err_q       <= 1'b0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    // Slave ready beats the watchdog in the same cycle.
                    if (slv_ready) begin
                        rdata_q <= slv_rdata;
                        state   <= RESP;
                    end else if (cnt == TMO) begin
                        rdata_q <= ERR_DATA;
                        err_q   <= 1'b1;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    cnt   <= '0;
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dm_read  = dm_sel && !req_q.write;
    assign dm_write = dm_sel &&  req_q.write;
    assign dm_addr  = dm_sel ? req_q.addr  : '0;
    assign dm_wdata = dm_sel ? req_q.wdata : '0;

    assign io_read  = io_sel && !req_q.write;
    assign io_write = io_sel &&  req_q.write;
    assign io_addr  = io_sel ? req_q.addr  : '0;
    assign io_wdata = io_sel ? req_q.wdata : '0;

    assign m0_ready = resp && !req_q.grant;
    assign m1_ready = resp &&  req_q.grant;
    assign m0_err   = m0_ready && err_q;
    assign m1_err   = m1_ready && err_q;
    assign m0_rdata = m0_ready ? rdata_q : '0;
    assign m1_rdata = m1_ready ? rdata_q : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed vector bench for bus_arbiter.
// Slave responders model wait states; vectors carry hand-computed results.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ready, m0_err, m1_ready, m1_err;
    logic        dm_read, dm_write, io_read, io_write;
    logic [31:0] dm_addr, dm_wdata, io_addr, io_wdata;
    logic [31:0] dm_rdata, io_rdata;
    logic        dm_ready, io_ready;
    logic        dm_rdy_r, io_rdy_r, dm_rdy_frc;

    int checks = 0;
    int errors = 0;
    int dm_wait = 0;
    int io_wait = 0;
    int dm_cnt = 0;
    int io_cnt = 0;

    always #5 clk = ~clk;

    assign dm_ready = dm_rdy_r | dm_rdy_frc;
    assign io_ready = io_rdy_r;

    bus_arbiter dut (
        .g_clk    (clk),
        .g_rst_n  (rst_n),
        .m0_read  (m0_read),
        .m0_write (m0_write),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_rdata (m0_rdata),
        .m0_ready (m0_ready),
        .m0_err   (m0_err),
        .m1_read  (m1_read),
        .m1_write (m1_write),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_rdata (m1_rdata),
        .m1_ready (m1_ready),
        .m1_err   (m1_err),
        .dm_read  (dm_read),
        .dm_write (dm_write),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_ready (dm_ready),
        .io_read  (io_read),
        .io_write (io_write),
        .io_addr  (io_addr),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata),
        .io_ready (io_ready)
    );

    // Slaves raise ready in strobe cycle wait+1.
    always @(negedge clk) begin
        if (dm_read || dm_write) begin
            dm_cnt++;
            dm_rdy_r = (dm_cnt == dm_wait + 1);
        end else begin
            dm_cnt = 0;
            dm_rdy_r = 1'b0;
        end
        if (io_read || io_write) begin
            io_cnt++;
            io_rdy_r = (io_cnt == io_wait + 1);
        end else begin
            io_cnt = 0;
            io_rdy_r = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time exceeded, got hang expected finish");
        $fatal(1);
    end

    typedef struct {
        string       name;
        logic        m;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        sel;
        int          wait_n;
        logic [31:0] rdata;
        logic        drop;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_stb;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(
        input string nm, input logic m, input logic rd,
        input logic wr, input logic [31:0] a,
        input logic [31:0] wd, input logic sel,
        input int wn, input logic [31:0] rdat,
        input logic drop, input logic [31:0] er,
        input logic ee, input int el, input int es
    );
        vec_t v;
        v.name = nm; v.m = m; v.rd = rd; v.wr = wr;
        v.addr = a; v.wdata = wd; v.sel = sel;
        v.wait_n = wn; v.rdata = rdat; v.drop = drop;
        v.exp_rdata = er; v.exp_err = ee;
        v.exp_lat = el; v.exp_stb = es;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic m, input logic rd,
                         input logic wr, input logic [31:0] a,
                         input logic [31:0] wd);
        if (m) begin
            m1_read = rd; m1_write = wr;
            m1_addr = a;  m1_wdata = wd;
        end else begin
            m0_read = rd; m0_write = wr;
            m0_addr = a;  m0_wdata = wd;
        end
    endtask

    task automatic run_txn(input vec_t v);
        int   lat = 0;
        int   stb = 0;
        int   bad = 0;
        int   bus_bad = 0;
        logic got = 1'b0;
        logic t_rd, t_wr, oth, rdy, orr, er;
        logic [31:0] rd_v, a_v, wd_v;
        dm_wait = v.wait_n; io_wait = v.wait_n;
        dm_rdata = v.rdata; io_rdata = v.rdata;
        @(negedge clk);
        drive(v.m, v.rd, v.wr, v.addr, v.wdata);
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            t_rd = v.sel ? io_read  : dm_read;
            t_wr = v.sel ? io_write : dm_write;
            a_v  = v.sel ? io_addr  : dm_addr;
            wd_v = v.sel ? io_wdata : dm_wdata;
            oth  = v.sel ? (dm_read | dm_write)
                         : (io_read | io_write);
            rdy  = v.m ? m1_ready : m0_ready;
            orr  = v.m ? m0_ready : m1_ready;
            er   = v.m ? m1_err   : m0_err;
            rd_v = v.m ? m1_rdata : m0_rdata;
            if (v.wr ? t_wr : t_rd) begin
                stb++;
                if (a_v !== v.addr) bus_bad++;
                if (v.wr && wd_v !== v.wdata) bus_bad++;
            end
            if ((v.wr ? t_rd : t_wr) || oth || orr) bad++;
            if (rdy) begin
                got = 1'b1;
                chk({v.name, "_err"}, 32'(er), 32'(v.exp_err));
                if (!v.wr)
                    chk({v.name, "_rdata"}, rd_v, v.exp_rdata);
            end
            if (v.drop && lat == 1)
                drive(v.m, 1'b0, 1'b0, v.addr, v.wdata);
        end
        drive(v.m, 1'b0, 1'b0, v.addr, v.wdata);
        chk({v.name, "_done"}, 32'(got), 32'd1);
        chk({v.name, "_lat"}, lat, v.exp_lat);
        chk({v.name, "_stb"}, stb, v.exp_stb);
        chk({v.name, "_bus"}, bus_bad, 0);
        chk({v.name, "_stray"}, bad, 0);
        @(negedge clk);
        chk({v.name, "_pulse"}, 32'(m0_ready | m1_ready), 32'd0);
    endtask

    task automatic dual(input string nm);
        int order[2];
        int done_cyc[2];
        int n = 0;
        int cyc = 0;
        logic [31:0] first_addr = '0;
        logic seen = 1'b0;
        order[0] = -1; order[1] = -1;
        done_cyc[0] = 0; done_cyc[1] = 0;
        dm_wait = 0; dm_rdata = 32'h1111_2222;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
        while (n < 2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (dm_read && !seen) begin
                seen = 1'b1;
                first_addr = dm_addr;
            end
            if (m0_ready && n < 2) begin
                order[n] = 0; done_cyc[n] = cyc; n++;
                m0_read = 1'b0;
            end
            if (m1_ready && n < 2) begin
                order[n] = 1; done_cyc[n] = cyc; n++;
                m1_read = 1'b0;
            end
        end
        m0_read = 1'b0; m1_read = 1'b0;
        chk({nm, "_count"}, n, 2);
        chk({nm, "_first"}, order[0], 0);
        chk({nm, "_second"}, order[1], 1);
        chk({nm, "_addr"}, first_addr, 32'h100);
        chk({nm, "_cyc1"}, done_cyc[0], 2);
        chk({nm, "_cyc2"}, done_cyc[1], 5);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        dm_rdata = '0; io_rdata = '0;
        dm_rdy_r = 1'b0; io_rdy_r = 1'b0; dm_rdy_frc = 1'b0;

        vecs[0] = mk("cpu_rd_dm", 0, 1, 0, 32'h0000_0010, 0,
                     0, 0, 32'h1234_5678, 0, 32'h1234_5678, 0, 2, 1);
        vecs[1] = mk("cpu_wr_io", 0, 0, 1, 32'hFFFF_0004,
                     32'h7F, 1, 3, 0, 0, 0, 0, 5, 4);
        vecs[2] = mk("m1_rd_io", 1, 1, 0, 32'hFFFF_0008, 0,
                     1, 1, 32'hA5A5_0001, 0, 32'hA5A5_0001, 0, 3, 2);
        vecs[3] = mk("m1_wr_dm", 1, 0, 1, 32'h0000_2000,
                     32'hCAFE_F00D, 0, 2, 0, 0, 0, 0, 4, 3);
        vecs[4] = mk("rd_wr_both", 0, 1, 1, 32'h0000_0040,
                     32'h0000_0099, 0, 0, 0, 0, 0, 0, 2, 1);
        vecs[5] = mk("drop_mid", 0, 1, 0, 32'hFFFE_0000, 0,
                     0, 2, 32'h0BAD_F00D, 1, 32'h0BAD_F00D, 0, 4, 3);
        vecs[6] = mk("timeout_io", 0, 1, 0, 32'hFFFF_0010, 0,
                     1, 255, 32'h1, 0, 32'hDEAD_BEEF, 1, 17, 16);
        vecs[7] = mk("coincide", 0, 1, 0, 32'h0000_0080, 0,
                     0, 15, 32'h55AA_55AA, 0, 32'h55AA_55AA, 0, 17, 16);
        vecs[8] = mk("m1_after_rst", 1, 1, 0, 32'h0000_0044, 0,
                     0, 0, 32'h0000_0001, 0, 32'h0000_0001, 0, 2, 1);

        repeat (2) @(negedge clk);
        chk("rst_strobes", 32'({m0_ready, m0_err, m1_ready, m1_err,
            dm_read, dm_write, io_read, io_write}), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        chk("rst_addr", dm_addr | io_addr | dm_wdata | io_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        dual("dual_a");
        dual("dual_b");

        dm_rdy_frc = 1'b1;
        @(negedge clk);
        dm_rdy_frc = 1'b0;
        chk("idle_rdy", 32'({m0_ready, m1_ready, dm_read, io_read}), 32'd0);
        @(negedge clk);
        chk("idle_rdy2", 32'({m0_ready, m1_ready, dm_read, io_read}), 32'd0);

        for (int i = 0; i < 8; i++)
            run_txn(vecs[i]);

        io_wait = 255;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'hFFFF_0020, 32'h0);
        repeat (3) @(negedge clk);
        chk("rst_mid_pre", 32'(io_read), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_strb", 32'({dm_read, dm_write, io_read, io_write}),
               32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rst_mid_rdy", 32'({m0_ready, m1_ready}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_rdy2", 32'({m0_ready, m1_ready, io_read}), 32'd0);
        run_txn(vecs[8]);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, two-slave data-bus arbiter that sits between the CPU data port, a second bus master (DMA/debug loader), the data memory and the IO bus (LED/button peripherals). It accepts one transaction at a time, chooses a master round-robin, decodes the address to a slave and sequences the read/write strobes. It returns ready and read data to the granted master. A watchdog counter terminates transactions to unresponsive slaves with an error.

## Interface
- `IO_BASE` — default 16'hFFFF — addr[31:16] value that selects the IO bus; any other value selects data memory.
- `TIMEOUT` — default 15 — maximum BUSY cycles before an error termination; legal range 1..255.
- `ERR_DATA` — default 32'hDEADBEEF — read data returned on timeout.
- `g_clk` input 1 — single system clock; all state changes on the rising edge.
- `g_rst_n` input 1 — asynchronous, active-low reset.
- `m0_read`, `m0_write` input 1 each — CPU request strobes, held until `m0_ready`.
- `m0_addr`, `m0_wdata` input 32 each — CPU address and write data, stable while a request is held.
- `m0_rdata` output 32 — read data to the CPU, valid while `m0_ready` is high.
- `m0_ready` output 1 — one-cycle completion pulse to the CPU.
- `m0_err` output 1 — high together with `m0_ready` when the transaction timed out.
- `m1_*` — the same seven signals for master 1.
- `dm_read`, `dm_write` output 1 each — data-memory strobes.
- `dm_addr`, `dm_wdata` output 32 each — data-memory address and write data.
- `dm_rdata` input 32 — data-memory read data.
- `dm_ready` input 1 — data-memory completion.
- `io_read`, `io_write`, `io_addr`, `io_wdata`, `io_rdata`, `io_ready` — the same six signals for the IO bus.

## Operation
- FSM states: IDLE, BUSY, RESP. Reset puts the FSM in IDLE.
- Reset values: all outputs 0; `last_grant` = 1; timeout counter = 0.
- IDLE:
  - A master is requesting when its read or write strobe is high.
  - If exactly one master is requesting, grant it.
  - If both are requesting, grant the master that is not `last_grant`.
  - On a grant, latch the grant, addr, wdata and direction, decode the target slave, then go to BUSY.
  - If read and write are both high on one master, it is a write.
- BUSY:
  - The selected slave's read or write strobe is held high; addr/wdata come from the latched copies.
  - The unselected slave's strobes are 0.
  - The counter increments each cycle.
  - On slave ready: capture slave rdata, go to RESP.
  - If the counter reaches TIMEOUT without ready: load ERR_DATA, set err, go to RESP.
  - Ready takes priority over timeout in the same cycle.
- RESP:
  - Drive ready (and err if set) to the granted master only, for exactly one cycle.
  - rdata comes from the register; it is also driven on writes, with an undefined value.
  - Update `last_grant`, clear the counter and err, return to IDLE.
- The master not granted sees ready = 0 and keeps waiting. It wins the next arbitration because `last_grant` has changed.
- A master that deasserts its strobe mid-transaction does not abort it. The transaction completes and its ready pulse is still issued.
- Slave ready outside BUSY is ignored.
- Reset asserted mid-transaction drops all strobes immediately. No ready pulse is issued.

## Timing
- Request sampled in IDLE at edge 0. Slave strobe is high from edge 1.
- Slave ready is sampled at edge k (k ≥ 1 cycle after the strobe rises). Master ready is high for the cycle after edge k+1.
- Minimum latency is 3 edges (zero-wait slave). The master sees ready in cycle 2.
- Back-to-back: IDLE re-arbitrates in the cycle after RESP, so there is at least one idle cycle between transactions.
- Timeout: err/ready are asserted TIMEOUT+1 cycles after the strobe rises.
- All outputs are registered or decoded from state plus latched registers. There is no combinational path from master inputs to slave outputs.

## Structure
- Shared package/constants: state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2), slave-select encoding (SEL_DM=0, SEL_IO=1), IO_BASE and ERR_DATA defaults.
- One sub-module, `rr_arbiter2`: a two-requester round-robin grant with a `last_grant` register and an update strobe. The FSM, decode and datapath stay in the top module.

## Test plan
- Single CPU read, addr 0x00000010, dm_ready in the cycle after dm_read rises, dm_rdata 0x12345678 -> m0_ready in cycle 2, m0_rdata 0x12345678, m0_err 0, io strobes never high.
- CPU write, addr 0xFFFF0004, wdata 0x7F, io_ready after 3 wait cycles -> io_write held 4 cycles with io_addr 0xFFFF0004, then one m0_ready pulse.
- Both masters request reads together from reset -> m0 served first, then m1. Repeat the simultaneous request -> m0 served first again, since `last_grant` is now 1.
- IO read, io_ready never asserted, TIMEOUT=15 -> m0_ready and m0_err high together 16 cycles after io_read rises, m0_rdata 0xDEADBEEF, FSM back in IDLE.
- g_rst_n pulled low during BUSY -> all strobes 0 asynchronously, no ready pulse. After release, a new m1 request completes normally.
- dm_ready and the timeout coincide (dm_ready in cycle TIMEOUT) -> m0_err 0 and the dm data is returned.
